mem_seq_ctrl: RTL and testbench

Request-sequencing front end for the single-port `memory` block (shared tri-state data bus, `wr`/`rd` strobes). It accepts one read or write request at a time over a valid/ready handshake and drives the memory's `wr`, `rd`, `addr` and `data` pins without bus contention. It captures read data and returns it on a single-cycle response strobe. It sits directly upstream of `memory` and replaces the hand-coded write/read task sequencing with synthesizable control.

---
 rtl/mem_seq_ctrl.sv | 95 +++++++++
 tb/tb_mem_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: one-at-a-time request sequencer in front of a
// single-port memory with a shared tri-state data bus.
module mem_seq_ctrl #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic [CWIDTH-1:0] wr_count,
  output logic [CWIDTH-1:0] rd_count
);

  // One-hot so each memory strobe is a bare flop output.
  localparam logic [3:0] IDLE  = 4'b0001;
  localparam logic [3:0] WRITE = 4'b0010;
  localparam logic [3:0] READ  = 4'b0100;
  localparam logic [3:0] RESP  = 4'b1000;

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic              lat_wr;
  logic [AWIDTH-1:0] lat_addr;
  logic [DWIDTH-1:0] lat_data;
  logic              accept;

  assign accept = state[0] && req_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:        state_nxt = !req_valid ? IDLE :
                               req_wr ? WRITE : READ;
      WRITE, READ: state_nxt = RESP;
      RESP:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = state[0];
    mem_wr    = state[1];
    mem_rd    = state[2];
    rsp_valid = state[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept) begin
      lat_wr   <= req_wr;
      lat_addr <= req_addr;
      lat_data <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           rsp_rdata <= '0;
    else if (state[2]) rsp_rdata <= mem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (state[3]) begin
      if (lat_wr && wr_count != '1)
        wr_count <= wr_count + CWIDTH'(1);
      if (!lat_wr && rd_count != '1)
        rd_count <= rd_count + CWIDTH'(1);
    end
  end

  assign mem_addr = lat_addr;
  assign mem_data = mem_wr ? lat_data : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: cycle-timed reference model, directed table,
// random traffic and reset/saturation sequences for mem_seq_ctrl.
module tb_mem_seq_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count;

  logic          req_ready4;
  logic          rsp_valid4;
  logic [DW-1:0] rsp_rdata4;
  logic          mem_wr4;
  logic          mem_rd4;
  logic [AW-1:0] mem_addr4;
  wire  [DW-1:0] mem_data4;
  logic [3:0]    wr_count4;
  logic [3:0]    rd_count4;

  mem_seq_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  mem_seq_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready4),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4),
    .mem_wr(mem_wr4), .mem_rd(mem_rd4), .mem_addr(mem_addr4),
    .mem_data(mem_data4),
    .wr_count(wr_count4), .rd_count(rd_count4)
  );

  // Behavioural single-port memory on the shared bus.
  logic [DW-1:0] mem_arr [32];
  always @(posedge clk) if (mem_wr) mem_arr[mem_addr] <= mem_data;
  assign mem_data = mem_rd ? mem_arr[mem_addr] : {DW{1'bz}};

  int checks = 0;
  int errors = 0;

  int cyc;
  int next_free;
  int strobe_cyc;
  int resp_cyc;
  bit            t_wr;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  logic [DW-1:0] ref_mem [32];
  bit            ref_known [32];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata;
  bit            m_rdata_known;
  int m_wr_cnt;
  int m_rd_cnt;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    next_free     = cyc + 1;
    strobe_cyc    = -1;
    resp_cyc      = -1;
    m_addr        = '0;
    m_rdata       = '0;
    m_rdata_known = 1'b1;
    m_wr_cnt      = 0;
    m_rd_cnt      = 0;
  endtask

  // Compare one cycle against the model, then drive the next inputs.
  task automatic step(input bit v, input bit w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit r, output bit acc);
    bit strobe;
    bit resp;
    @(negedge clk);
    acc    = 1'b0;
    strobe = (cyc == strobe_cyc);
    resp   = (cyc == resp_cyc);
    if (resp && !t_wr) begin
      m_rdata       = ref_mem[t_addr];
      m_rdata_known = ref_known[t_addr];
    end
    chk("req_ready", req_ready, 32'(cyc >= next_free));
    chk("mem_wr", mem_wr, 32'(strobe && t_wr));
    chk("mem_rd", mem_rd, 32'(strobe && !t_wr));
    chk("rsp_valid", rsp_valid, 32'(resp));
    chk("mem_addr", mem_addr, 32'(m_addr));
    if (strobe && t_wr)
      chk("mem_data_wr", mem_data, 32'(t_data));
    else if (strobe) begin
      if (ref_known[t_addr])
        chk("mem_data_rd", mem_data, 32'(ref_mem[t_addr]));
    end else
      chk("mem_data_z", mem_data, 32'({DW{1'bz}}));
    if (m_rdata_known) chk("rsp_rdata", rsp_rdata, 32'(m_rdata));
    chk("wr_count", wr_count, 32'(m_wr_cnt));
    chk("rd_count", rd_count, 32'(m_rd_cnt));
    chk("wr_count4", wr_count4, 32'(m_wr_cnt > 15 ? 15 : m_wr_cnt));
    chk("rd_count4", rd_count4, 32'(m_rd_cnt > 15 ? 15 : m_rd_cnt));

    req_valid = v;
    req_wr    = w;
    req_addr  = a;
    req_wdata = d;
    rst       = r;

    if (strobe && t_wr) begin
      ref_mem[t_addr]   = t_data;
      ref_known[t_addr] = 1'b1;
    end
    if (r) model_reset();
    else begin
      if (resp) begin
        if (t_wr) m_wr_cnt = (m_wr_cnt >= 65535) ? 65535 : m_wr_cnt + 1;
        else      m_rd_cnt = (m_rd_cnt >= 65535) ? 65535 : m_rd_cnt + 1;
      end
      if (v && cyc >= next_free) begin
        acc        = 1'b1;
        t_wr       = w;
        t_addr     = a;
        t_data     = d;
        m_addr     = a;
        strobe_cyc = cyc + 1;
        resp_cyc   = cyc + 2;
        next_free  = cyc + 3;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    step(0, 0, '0, '0, 1, acc);
    idle(1);
  endtask

  task automatic wait_accept(input bit w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1, w, a, d, 0, acc);
      n++;
    end while (!acc && n < 10);
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic txn(input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output logic [DW-1:0] rd);
    wait_accept(w, a, d);
    idle(2);
    rd = rsp_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    bit acc;

    tbl[0] = '{1'b1, 5'd5,  8'hA5, 8'h00};
    tbl[1] = '{1'b0, 5'd5,  8'h00, 8'hA5};
    tbl[2] = '{1'b1, 5'd0,  8'h00, 8'h00};
    tbl[3] = '{1'b1, 5'd31, 8'hFF, 8'h00};
    tbl[4] = '{1'b0, 5'd0,  8'h00, 8'h00};
    tbl[5] = '{1'b0, 5'd31, 8'h00, 8'hFF};
    tbl[6] = '{1'b1, 5'd5,  8'h5A, 8'h00};
    tbl[7] = '{1'b0, 5'd5,  8'h00, 8'h5A};
    tbl[8] = '{1'b1, 5'd31, 8'h81, 8'h00};
    tbl[9] = '{1'b0, 5'd31, 8'h00, 8'h81};

    for (int i = 0; i < 32; i++) ref_known[i] = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    cyc       = 0;
    repeat (2) @(posedge clk);
    model_reset();
    next_free = 0;

    idle(2);

    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].data, rd);
      if (!tbl[i].wr) chk("tbl_rdata", 32'(rd), 32'(tbl[i].exp));
    end

    do_reset();
    for (int i = 0; i < 31; i++)
      txn(1'b1, AW'(31 - i), DW'(i), rd);
    for (int i = 0; i < 31; i++) begin
      txn(1'b0, AW'(31 - i), '0, rd);
      chk("fill_rdata", 32'(rd), 32'(i));
    end
    idle(1);
    chk("fill_wr_count", wr_count, 32'd31);
    chk("fill_rd_count", rd_count, 32'd31);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom),
           AW'($urandom), DW'($urandom), 0, acc);

    for (int i = 0; i < 30; i++)
      step(1, 1'($urandom), AW'($urandom), DW'($urandom), 0, acc);
    idle(3);

    wait_accept(1'b0, 5'd7, '0);
    step(0, 0, '0, '0, 1, acc);
    idle(3);
    wait_accept(1'b1, 5'd3, 8'h3C);
    step(0, 0, '0, '0, 1, acc);
    idle(3);
    wait_accept(1'b1, 5'd9, 8'h99);
    idle(1);
    step(0, 0, '0, '0, 1, acc);
    idle(2);
    step(1, 1, 5'd4, 8'h44, 1, acc);
    idle(2);
    txn(1'b0, 5'd3, '0, rd);
    chk("rst_write_kept", 32'(rd), 32'h3C);

    do_reset();
    for (int i = 0; i < 20; i++)
      txn(1'b1, AW'(i), DW'(i * 7), rd);
    idle(1);
    chk("sat_wr_count4", wr_count4, 32'hF);
    chk("sat_rd_count4", rd_count4, 32'h0);
    chk("sat_wr_count", wr_count, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
